// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide at one bit per cycle; divide-by-zero and signed overflow finish on accept.
module riscv_muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      Operation,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  op_t              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_opnd, r_acc, r_lo, r_result;
  logic             r_neg_res, r_neg_rem;

  // Accept-time decode
  op_t             w_op;
  logic            w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic            w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_special_res;

  assign w_op       = op_t'(Operation);
  assign w_accept   = (r_state == S_IDLE) && InValid && !Flush;
  assign w_a_sgn    = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                      (w_op == OP_DIV)  || (w_op == OP_REM);
  assign w_b_sgn    = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_a_neg    = w_a_sgn && SrcA[XLEN-1];
  assign w_b_neg    = w_b_sgn && SrcB[XLEN-1];
  assign w_a_mag    = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag    = w_b_neg ? -SrcB : SrcB;
  assign w_div_zero = Operation[2] && (SrcB == '0);
  assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (SrcA == MIN_NEG) && (SrcB == '1);
  assign w_special  = w_div_zero || w_ovf;

  // Operation[1] separates remainder from quotient in the divide group
  always_comb begin
    if (w_div_zero) w_special_res = Operation[1] ? SrcA : '1;
    else            w_special_res = Operation[1] ? '0   : SrcA;
  end

  // One iteration: {r_acc, r_lo} is the product register for multiply and
  // {remainder, dividend/quotient} for divide; r_opnd holds the fixed operand.
  logic            w_is_div, w_ge;
  logic [XLEN:0]   w_sum, w_shl;
  logic [XLEN-1:0] w_diff, w_acc_nxt, w_lo_nxt;

  assign w_is_div = r_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_opnd};
  assign w_shl    = {r_acc, r_lo[XLEN-1]};
  assign w_ge     = (w_shl >= {1'b0, r_opnd});
  assign w_diff   = w_shl[XLEN-1:0] - r_opnd;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_acc_nxt = r_acc;
    w_lo_nxt  = r_lo;
    if (w_is_div) begin
      w_acc_nxt = w_ge ? w_diff : w_shl[XLEN-1:0];
      w_lo_nxt  = {r_lo[XLEN-2:0], w_ge};
    end else if (r_lo[0]) begin
      {w_acc_nxt, w_lo_nxt} = {w_sum, r_lo[XLEN-1:1]};
    end else begin
      {w_acc_nxt, w_lo_nxt} = {1'b0, r_acc, r_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the values produced by the final iteration
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;

  assign w_prod     = {w_acc_nxt, w_lo_nxt};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_res ? -w_lo_nxt : w_lo_nxt;
  assign w_rem_fix  = r_neg_rem ? -w_acc_nxt : w_acc_nxt;

  always_comb begin
    case (r_op)
      OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quo_fix;
      default:                      w_final = w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (Flush) w_state_nxt = S_IDLE;
               else if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  if (Flush || OutReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_result  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_op      <= w_op;
      r_cnt     <= CNT_INIT;
      r_acc     <= '0;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_opnd    <= Operation[2] ? w_b_mag : w_a_mag;
      r_lo      <= Operation[2] ? w_a_mag : w_b_mag;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - CNT_LAST;
      r_acc <= w_acc_nxt;
      r_lo  <= w_lo_nxt;
      if ((r_cnt == CNT_LAST) && !Flush) r_result <= w_final;
    end
  end

  assign InReady  = (r_state == S_IDLE);
  assign OutValid = (r_state == S_DONE);
  assign Busy     = (r_state != S_IDLE);
  assign Result   = r_result;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: stimulus pushes reference results,
// a negedge monitor pops and compares on every delivered result.
module tb_riscv_muldiv_unit;
  localparam int          XLEN    = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [2:0]  MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0]  DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0, rst_n = 1'b0, Flush = 1'b0, InValid = 1'b0, OutReady = 1'b1;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic [2:0]  Operation = '0;
  logic        InReady, OutValid, Busy;
  logic [31:0] Result;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .OutValid(OutValid),
    .OutReady(OutReady), .Result(Result), .Busy(Busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic and native signed division
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, ua, sb, ub, p;
    int          si, sj;
    sa = {{32{a[31]}}, a};  ua = {32'd0, a};
    sb = {{32{b[31]}}, b};  ub = {32'd0, b};
    si = a;  sj = b;
    case (op)
      MUL:    begin p = ua * ub; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    if (b == 0) return '1; else if (a == MIN_NEG && b == '1) return a;
              else return si / sj;
      DIVU:   if (b == 0) return '1; else return a / b;
      REM:    if (b == 0) return a; else if (a == MIN_NEG && b == '1) return '0;
              else return si % sj;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == DIV || op == REM) && a == MIN_NEG && b == '1) return 1;
    return XLEN + 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && OutValid && OutReady && !Flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %h, none expected (t=%0t)", Result, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", Result, mon_exp);
      end
    end
  end

  // Leaves the bench 1 time unit after the accept edge; operands are scrambled afterwards.
  task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit push);
    int guard = 0;
    while (!InReady && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", InReady, 1);
    SrcA = a; SrcB = b; Operation = op; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    Operation = 3'($urandom);
    SrcA = $urandom;
    SrcB = $urandom;
    if (push) exp_q.push_back(ref_result(op, a, b));
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat = 1;
    while (!OutValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    OutReady = (hold == 0);
    accept_op(op, a, b, 1'b1);
    wait_valid(exp_latency(op, a, b));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", OutValid, 1);
      check("hold_result", Result, exp);
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after", InReady, 1);
    check("out_valid_after", OutValid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    #22;
    check("rst_in_ready", InReady, 1);
    check("rst_out_valid", OutValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_result", Result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(MUL, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(MULHU, '1, '1, 0);
    run_op(MULH, '1, '1, 0);
    run_op(MULHSU, '1, '1, 0);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(DIVU, 32'd100, 32'd7, 0);
    run_op(REMU, 32'd100, 32'd7, 0);
    run_op(DIVU, 32'd5, 32'd0, 0);
    run_op(REM, 32'd5, 32'd0, 0);
    run_op(DIV, MIN_NEG, '1, 0);
    run_op(REM, MIN_NEG, '1, 0);

    run_op(DIVU, 32'd100, 32'd7, 10);

    // Flush during the fifth CALC cycle
    accept_op(MUL, 32'd5, 32'd6, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_in_ready", InReady, 1);
    check("flush_out_valid", OutValid, 0);
    check("flush_busy", Busy, 0);
    run_op(MUL, 32'd3, 32'd4, 0);

    // Flush in IDLE blocks acceptance
    SrcA = 32'd9; SrcB = 32'd3; Operation = DIVU; InValid = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    check("idle_flush_busy", Busy, 0);
    check("idle_flush_in_ready", InReady, 1);

    // Asynchronous reset in the middle of CALC
    accept_op(DIVU, 32'd1000, 32'd7, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", Busy, 0);
    check("async_rst_in_ready", InReady, 1);
    check("async_rst_out_valid", OutValid, 0);
    check("async_rst_result", Result, 0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(DIVU, 32'd9, 32'd3, 0);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = MIN_NEG; b = '1; end
        2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        3: begin a = -$urandom_range(0, 255); b = -$urandom_range(1, 15); end
        default: ;
      endcase
      run_op(op, a, b, $urandom_range(0, 3));
    end

    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
